fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// - Sequences the program counter and drives instruction fetch for the single-cycle core.
// - Owns pc, issues one request at a time on a req/gnt/rvalid imem port, presents each word on a valid/ready port.
// - Applies next-pc selection as each instruction is accepted: sequential pc+4, branch pc+imm, or jalr absolute.
// - Sits between the instruction memory and the decode/execute stage.
// PARAMETERS
// - RESET_PC  32'h0000_0000  pc loaded on reset
// - TRAP_VEC  32'h0000_0100  pc loaded on misaligned-target trap (PC_MISALIGN_TRAP_EN only)
// PORTS
// - clk_i           in   1   clock, rising edge
// - rst_i           in   1   reset, asynchronous, active-high
// - imem_req_o      out  1   fetch request, held high until granted
// - imem_addr_o     out  32  fetch address (= pc); stable while imem_req_o is high
// - imem_gnt_i      in   1   request accepted this cycle
// - imem_rvalid_i   in   1   read data valid
// - imem_rdata_i    in   32  instruction word
// - instr_valid_o   out  1   instruction available to core
// - instr_o         out  32  instruction word, held while instr_valid_o is high
// - instr_pc_o      out  32  pc of instr_o
// - instr_ready_i   in   1   core accepts instr_o this cycle
// - branch_i        in   1   taken branch/jal for the accepted instruction
// - branch_imm_i    in   32  sign-extended offset, relative to instr_pc_o
// - jalr_i          in   1   jalr for the accepted instruction
// - jalr_tgt_i      in   32  absolute jalr target
// - trap_o          out  1   1-cycle pulse, misaligned target (PC_MISALIGN_TRAP_EN only, else tied 0)
// BEHAVIOUR
// - FSM states: BOOT, REQ, RESP, DELIVER.
//   - Reset enters BOOT.
//   - BOOT->REQ after 1 cycle.
//   - REQ->RESP when imem_gnt_i=1.
//   - RESP->DELIVER when imem_rvalid_i=1.
//   - DELIVER->REQ when instr_valid_o&instr_ready_i.
// - Reset values: pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=RESET_PC, trap_o=0.
// - Outputs:
//   - imem_req_o=1 only in REQ.
//   - instr_valid_o=1 only in DELIVER.
//   - instr_o/instr_pc_o are registered on the rvalid cycle.
// - Latency: minimum 3 cycles from the accept handshake to the next instr_valid_o (REQ gnt, RESP rvalid, DELIVER), with zero-wait memory.
// - Next pc is computed on the accept cycle only; branch_i and jalr_i are ignored on all other cycles.
//   - jalr_i=1 -> jalr_tgt_i.
//   - else branch_i=1 -> instr_pc_o + branch_imm_i.
//   - else instr_pc_o + 4.
//   - jalr_i has priority if both are set.
// - Arithmetic is 32-bit modulo 2^32, carry discarded: 0xFFFF_FFFC+4 -> 0x0000_0000; 0x0000_0008+0xFFFF_FFF8 -> 0x0000_0000.
// - Wait states:
//   - gnt low: stay in REQ with imem_addr_o stable.
//   - rvalid low: stay in RESP.
//   - instr_ready_i low: stay in DELIVER with instr_o and instr_pc_o stable.
// - imem_rvalid_i outside RESP is ignored (covers a stale response after reset).
// - imem_gnt_i outside REQ is ignored.
// - Reset asserted mid-operation: immediate return to reset values and BOOT; the in-flight request is abandoned.
// - Only one outstanding request at any time.
// CONFIGURATION
// - Macro: PC_MISALIGN_TRAP_EN.
// - Defined: a next pc with [1:0]!=0 is not loaded.
//   - pc <= TRAP_VEC.
//   - trap_o pulses 1 cycle, coincident with the first REQ cycle.
// - Undefined:
//   - Next pc bits [1:0] are forced to 2'b00; no trap.
//   - trap_o is tied 0.
// TESTING
// - Reset, zero-wait memory, ready=1:
//   - First req addr 0x0.
//   - Then 0x4, 0x8, 0xC.
//   - instr_valid_o every 3rd cycle.
//   - instr_o equals memory contents.
// - gnt delayed 2 cycles and ready low 3 cycles: imem_addr_o and instr_o are held constant; no request is issued while in DELIVER.
// - Branches:
//   - At pc 0x10, branch_i=1, imm=0xFFFF_FFF0: next req addr 0x0.
//   - At pc 0x20, branch_i=1 with ready=0: ignored.
// - Both jalr and branch, jalr_tgt_i=0x200, imm=0x8, at pc 0x40: next req addr 0x200.
// - Wrap: RESET_PC=0xFFFF_FFFC: second req addr 0x0000_0000.
// - Reset in RESP, then a stale rvalid in BOOT: ignored.
//   - Next req addr RESET_PC.
//   - No instr_valid_o until the new response.
// - Misaligned target, jalr_tgt_i=0x202:
//   - With PC_MISALIGN_TRAP_EN: trap_o pulse, next req addr TRAP_VEC.
//   - Without: next req addr 0x200.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter of the single-cycle core. It issues one instruction
// fetch at a time on a req/gnt/rvalid memory port. Each returned word is
// presented to decode/execute on a valid/ready port. When the core accepts a
// word, the next pc is selected: sequential (pc+4), branch (pc+imm) or jalr
// (absolute target).
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   imem_req_o          fetch request, held until granted
//   imem_addr_o         fetch address (the current pc)
//   imem_gnt_i          memory accepted the request
//   imem_rvalid_i       memory read data valid
//   imem_rdata_i        instruction word from memory
//   instr_valid_o       instruction available to the core
//   instr_o             instruction word
//   instr_pc_o          pc of instr_o
//   instr_ready_i       core accepts instr_o this cycle
//   branch_i            taken branch/jal for the accepted instruction
//   branch_imm_i        sign-extended offset relative to instr_pc_o
//   jalr_i              jalr for the accepted instruction (wins over branch_i)
//   jalr_tgt_i          absolute jalr target
//   trap_o              one-cycle misaligned-target pulse
//
// Configuration macro: PC_MISALIGN_TRAP_EN
//   defined   : a misaligned next pc redirects to TRAP_VEC and pulses trap_o
//   undefined : next pc bits [1:0] are cleared and trap_o is tied low
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_imm_i,
    input  logic        jalr_i,
    input  logic [31:0] jalr_tgt_i,
    output logic        trap_o
);

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        RESP,
        DELIVER
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        accept;

    // The next pc is only loaded on the cycle the core accepts an instruction.
    assign accept = (state == DELIVER) && instr_ready_i;

    // The address must stay stable while the request waits for a grant.
    // Because pc only changes on accept, driving the address from pc is enough.
    assign imem_addr_o = pc;

    // Raw target. The adds wrap modulo 2^32 and the carry is dropped.
    always_comb begin
        if (jalr_i) begin
            target = jalr_tgt_i;
        end else if (branch_i) begin
            target = instr_pc_o + branch_imm_i;
        end else begin
            target = instr_pc_o + 32'd4;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_q;

    assign misaligned = (target[1:0] != 2'b00);
    assign next_pc    = misaligned ? TRAP_VEC : target;

    // The pulse is registered on accept. This makes it coincide with the first
    // REQ cycle of the redirected fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= accept && misaligned;
        end
    end

    assign trap_o = trap_q;
`else
    logic unused_trap_vec;

    assign next_pc         = target & ~32'h0000_0003;
    assign trap_o          = 1'b0;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. gnt and rvalid are only looked at in the state that
    // expects them, so a stale response after reset has no effect.
    always_comb begin
        next_state = state;
        unique case (state)
            BOOT:    next_state = REQ;
            REQ:     if (imem_gnt_i)    next_state = RESP;
            RESP:    if (imem_rvalid_i) next_state = DELIVER;
            DELIVER: if (instr_ready_i) next_state = REQ;
            default: next_state = BOOT;
        endcase
    end

    // Output decode
    always_comb begin
        imem_req_o    = (state == REQ);
        instr_valid_o = (state == DELIVER);
    end

    // The pc and the delivered instruction/pc pair.
    // instr_o and instr_pc_o only load on the rvalid cycle. That holds them
    // stable for as long as DELIVER waits for ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc         <= RESET_PC;
            instr_o    <= 32'h0000_0000;
            instr_pc_o <= RESET_PC;
        end else begin
            if ((state == RESP) && imem_rvalid_i) begin
                instr_o    <= imem_rdata_i;
                instr_pc_o <= pc;
            end
            if (accept) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. A transaction-level model tracks the
// expected pc, the outstanding request and the word waiting for the core.
// The model is compared against the DUT on every falling edge. Directed
// sequences also pin selected values with literal expectations.
// A second instance, with RESET_PC at the top of the address space, checks
// that the pc wraps to zero.
// Inputs are driven 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_imm_i = 32'h0;
    logic        jalr_i = 1'b0;
    logic [31:0] jalr_tgt_i = 32'h0;
    logic        trap_o;

    // Wrap-check instance: memory always grants and responds, core always ready
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_trap;
    logic [31:0] w_seen [2];
    int          w_cnt = 0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int acc_cyc    = 0;

    // Model state
    logic [31:0] m_pc;
    logic        m_boot;
    logic        m_pend;
    logic [31:0] m_pend_addr;
    logic        m_full;
    logic [31:0] m_slot;
    logic        m_trap;

    fetch_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i),
        .branch_i(branch_i), .branch_imm_i(branch_imm_i),
        .jalr_i(jalr_i), .jalr_tgt_i(jalr_tgt_i), .trap_o(trap_o)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TRAP_VEC(TRAP_VEC)) u_wrap (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_gnt_i(1'b1), .imem_rvalid_i(1'b1),
        .imem_rdata_i(32'h0000_0013),
        .instr_valid_o(w_valid), .instr_o(w_instr),
        .instr_pc_o(w_instr_pc), .instr_ready_i(1'b1),
        .branch_i(1'b0), .branch_imm_i(32'h0),
        .jalr_i(1'b0), .jalr_tgt_i(32'h0), .trap_o(w_trap)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory contents: an arbitrary but address-unique pattern
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the transaction model. After checking,
    // the model is advanced by the handshake that will complete at the
    // coming rising edge. The inputs are already stable at this point.
    always @(negedge clk_i) begin
        logic        exp_req;
        logic [31:0] tgt;
        if (rst_i) begin
            m_pc   = RESET_PC;
            m_boot = 1'b1;
            m_pend = 1'b0;
            m_full = 1'b0;
            m_trap = 1'b0;
            checkOutput("rst_req", {31'b0, imem_req_o}, 32'd0);
            checkOutput("rst_valid", {31'b0, instr_valid_o}, 32'd0);
            checkOutput("rst_addr", imem_addr_o, RESET_PC);
        end else begin
            exp_req = !m_boot && !m_pend && !m_full;
            checkOutput("req", {31'b0, imem_req_o}, {31'b0, exp_req});
            if (exp_req) checkOutput("addr", imem_addr_o, m_pc);
            checkOutput("valid", {31'b0, instr_valid_o}, {31'b0, m_full});
            if (m_full) begin
                checkOutput("instr", instr_o, mem_word(m_slot));
                checkOutput("instr_pc", instr_pc_o, m_slot);
            end
            checkOutput("trap", {31'b0, trap_o}, {31'b0, m_trap});
            m_trap = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (exp_req && imem_gnt_i) begin
                m_pend      = 1'b1;
                m_pend_addr = m_pc;
            end else if (m_pend && imem_rvalid_i) begin
                m_pend = 1'b0;
                m_full = 1'b1;
                m_slot = m_pend_addr;
            end else if (m_full && instr_ready_i) begin
                m_full = 1'b0;
                if (jalr_i)        tgt = jalr_tgt_i;
                else if (branch_i) tgt = m_slot + branch_imm_i;
                else               tgt = m_slot + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
                if (tgt % 4 != 0) begin
                    m_pc   = TRAP_VEC;
                    m_trap = 1'b1;
                end else begin
                    m_pc = tgt;
                end
`else
                m_pc = tgt - (tgt % 4);
`endif
            end
        end
    end

    // Record the first two fetch addresses of the wrap instance
    always @(negedge clk_i) begin
        if (!rst_i && w_req && w_cnt < 2) begin
            w_seen[w_cnt] = w_addr;
            w_cnt++;
        end
    end

    // Drive one complete fetch: optional grant, response and ready wait
    // states, then accept with the given redirect. With noise set, the wait
    // cycles carry bogus branch/jalr requests, which must be ignored.
    task automatic applyStimulus(input int gnt_wait, input int rv_wait,
                                 input int rdy_wait, input bit noise,
                                 input logic br, input logic [31:0] imm,
                                 input logic jr, input logic [31:0] tgt,
                                 output logic [31:0] req_addr);
        int n = 0;
        while (!imem_req_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!imem_req_o) begin
            checkOutput("req_timeout", 32'd0, 32'd1);
            req_addr = 32'hDEAD_BEEF;
            return;
        end
        branch_i = noise; branch_imm_i = 32'h100;
        jalr_i   = noise; jalr_tgt_i   = 32'h300;
        for (int i = 0; i < gnt_wait; i++) begin
            imem_gnt_i = 1'b0;
            @(posedge clk_i); #1;
        end
        imem_gnt_i = 1'b1;
        req_addr   = imem_addr_o;
        @(posedge clk_i); #1;
        imem_gnt_i = 1'b0;
        for (int i = 0; i < rv_wait; i++) begin
            @(posedge clk_i); #1;
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(req_addr);
        @(posedge clk_i); #1;
        imem_rvalid_i = 1'b0;
        for (int i = 0; i < rdy_wait; i++) begin
            instr_ready_i = 1'b0;
            @(posedge clk_i); #1;
        end
        instr_ready_i = 1'b1;
        branch_i = br; branch_imm_i = imm;
        jalr_i   = jr; jalr_tgt_i   = tgt;
        @(posedge clk_i); #1;
        instr_ready_i = 1'b0;
        branch_i = 1'b0; jalr_i = 1'b0;
        acc_cyc = cyc;
    endtask

    initial begin
        logic [31:0] a;
        int          c0;
        int          c1;
        int          c2;

        // Reset values
        @(posedge clk_i); #1;
        checkOutput("reset_req", {31'b0, imem_req_o}, 32'd0);
        checkOutput("reset_valid", {31'b0, instr_valid_o}, 32'd0);
        checkOutput("reset_addr", imem_addr_o, 32'h0);
        checkOutput("reset_instr", instr_o, 32'h0);
        checkOutput("reset_instr_pc", instr_pc_o, 32'h0);
        checkOutput("reset_trap", {31'b0, trap_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Zero-wait sequential fetch
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, a);
        checkOutput("seq_addr0", a, 32'h0);
        c0 = acc_cyc;
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, a);
        checkOutput("seq_addr1", a, 32'h4);
        c1 = acc_cyc;
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, a);
        checkOutput("seq_addr2", a, 32'h8);
        c2 = acc_cyc;
        checkOutput("seq_interval1", c1 - c0, 32'd3);
        checkOutput("seq_interval2", c2 - c1, 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, a);
        checkOutput("seq_addr3", a, 32'hC);

        // Backward branch at 0x10, with a late grant and a slow core
        applyStimulus(2, 1, 3, 0, 1, 32'hFFFF_FFF0, 0, 32'h0, a);
        checkOutput("br_at", a, 32'h10);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h20, a);
        checkOutput("br_target", a, 32'h0);

        // Redirect requests while ready is low are ignored
        applyStimulus(1, 0, 3, 1, 0, 32'h0, 0, 32'h0, a);
        checkOutput("noise_at", a, 32'h20);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h40, a);
        checkOutput("noise_next", a, 32'h24);

        // jalr wins over branch
        applyStimulus(0, 0, 0, 0, 1, 32'h8, 1, 32'h200, a);
        checkOutput("prio_at", a, 32'h40);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h202, a);
        checkOutput("prio_target", a, 32'h200);

        // Misaligned jalr target 0x202
`ifdef PC_MISALIGN_TRAP_EN
        checkOutput("misalign_trap", {31'b0, trap_o}, 32'd1);
`else
        checkOutput("misalign_trap", {31'b0, trap_o}, 32'd0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h8, a);
`ifdef PC_MISALIGN_TRAP_EN
        checkOutput("misalign_next", a, 32'h100);
`else
        checkOutput("misalign_next", a, 32'h200);
`endif

        // 0x8 + 0xFFFF_FFF8 wraps to 0
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0, a);
        checkOutput("mod_at", a, 32'h8);

        // Reset while waiting in RESP, then a stale rvalid during BOOT
        a = 0;
        while (!imem_req_o && a < 20) begin
            @(posedge clk_i); #1;
            a++;
        end
        imem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        imem_gnt_i = 1'b0;
        rst_i      = 1'b1;
        #1;
        checkOutput("midrst_addr", imem_addr_o, RESET_PC);
        @(posedge clk_i); #1;
        rst_i         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
        @(posedge clk_i); #1;
        imem_rvalid_i = 1'b0;
        checkOutput("stale_valid", {31'b0, instr_valid_o}, 32'd0);
        applyStimulus(0, 2, 0, 0, 0, 32'h0, 0, 32'h0, a);
        checkOutput("midrst_next", a, RESET_PC);
        applyStimulus(0, 0, 1, 0, 0, 32'h0, 0, 32'h0, a);
        checkOutput("midrst_seq", a, 32'h4);

        // Wrap instance: RESET_PC 0xFFFF_FFFC, then 0x0
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("wrap_count", w_cnt, 32'd2);
        checkOutput("wrap_first", w_seen[0], 32'hFFFF_FFFC);
        checkOutput("wrap_second", w_seen[1], 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
